// File: rtl/hcordic_seq_pkg.sv
// Shared widths, index constants and state encoding for the hyperbolic CORDIC sequencer.
package hcordic_seq_pkg;

  localparam int unsigned FLOAT_SIZE = 24;
  localparam int unsigned INT_SIZE   = 8;
  localparam int unsigned WORD_W     = INT_SIZE + FLOAT_SIZE;
  localparam int unsigned INDEX_W    = 5;

  typedef logic signed [WORD_W-1:0]  q8_24_t;
  typedef logic signed [INDEX_W-1:0] index_t;

  localparam index_t REPEAT_IDX_A = index_t'(4);
  localparam index_t REPEAT_IDX_B = index_t'(13);
  localparam index_t MAX_INDEX    = index_t'(13);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Indices whose step must be issued twice for hyperbolic convergence.
  function automatic logic is_repeat_idx(input index_t idx);
    return (idx == REPEAT_IDX_A) || (idx == REPEAT_IDX_B);
  endfunction

endpackage

// File: rtl/hcordic_seq_if.sv
// Start/done and iteration-command handshake bundle between the sequencer and its user.
interface hcordic_seq_if;
  import hcordic_seq_pkg::*;

  logic   start;
  logic   mode;
  q8_24_t z_in;
  logic   ready;
  logic   iter_valid;
  logic   iter_ready;
  index_t iter_index;
  logic   iter_dir;
  logic   y_neg;
  logic   done;
  q8_24_t z_out;

  modport master (
    output start, mode, z_in, iter_ready, y_neg,
    input  ready, iter_valid, iter_index, iter_dir, done, z_out
  );

  modport slave (
    input  start, mode, z_in, iter_ready, y_neg,
    output ready, iter_valid, iter_index, iter_dir, done, z_out
  );

endinterface

// File: rtl/hcordic_seq_atanh_lookup.sv
// Combinational Q8.24 angle table; indices <= 0 hold the expanded-range
// angles atanh(1 - 2^(i-2)), positive indices hold atanh(2^-i).
module atanh_lookup
  import hcordic_seq_pkg::*;
(
  input  index_t index_i,
  output q8_24_t angle_o
);

  always_comb begin
    angle_o = '0;
    case (index_i)
      index_t'(-3): angle_o = 32'sd34755133;
      index_t'(-2): angle_o = 32'sd28806373;
      index_t'(-1): angle_o = 32'sd22716772;
      index_t'(0):  angle_o = 32'sd16323477;
      index_t'(1):  angle_o = 32'sd9215828;
      index_t'(2):  angle_o = 32'sd4285116;
      index_t'(3):  angle_o = 32'sd2108178;
      index_t'(4):  angle_o = 32'sd1049945;
      index_t'(5):  angle_o = 32'sd524459;
      index_t'(6):  angle_o = 32'sd262165;
      index_t'(7):  angle_o = 32'sd131075;
      index_t'(8):  angle_o = 32'sd65536;
      index_t'(9):  angle_o = 32'sd32768;
      index_t'(10): angle_o = 32'sd16384;
      index_t'(11): angle_o = 32'sd8192;
      index_t'(12): angle_o = 32'sd4096;
      index_t'(13): angle_o = 32'sd2048;
      default:      angle_o = '0;
    endcase
  end

endmodule

// File: rtl/hcordic_seq.sv
// Hyperbolic CORDIC angle sequencer: issues expanded-range iteration commands
// to an external x/y datapath and accumulates the z angle.
module hcordic_seq
  import hcordic_seq_pkg::*;
#(
  parameter int unsigned NEG_ITERS = 4
) (
  input  logic         clk,
  input  logic         rst,
  hcordic_seq_if.slave bus
);

  localparam index_t FIRST_IDX = index_t'(1 - int'(NEG_ITERS));

  logic [1:0] state_q, state_d;
  index_t     idx_q, idx_d;
  logic       rep_q, rep_d;
  logic       mode_q, mode_d;
  q8_24_t     acc_q, acc_d;
  q8_24_t     z_out_q, z_out_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  q8_24_t     angle_c;
  logic       hs_c, last_c, dir_c;

  atanh_lookup u_atanh_lookup (
    .index_i (idx_q),
    .angle_o (angle_c)
  );

  assign hs_c   = valid_q & bus.iter_ready;
  assign last_c = hs_c & rep_q & (idx_q == MAX_INDEX);
  // Vectoring follows y_neg live so the datapath sees its own sign in the handshake cycle.
  assign dir_c  = valid_q & (mode_q ? bus.y_neg : ~acc_q[WORD_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rep_q   <= 1'b0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      z_out_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      z_out_q <= z_out_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next state, index/repeat stepping and z accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    z_out_d = z_out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          idx_d   = FIRST_IDX;
          rep_d   = 1'b0;
          mode_d  = bus.mode;
          acc_d   = bus.z_in;
        end
      end
      ST_RUN: begin
        if (hs_c) begin
          acc_d = dir_c ? (acc_q - angle_c) : (acc_q + angle_c);
          if (last_c) begin
            state_d = ST_DONE;
            rep_d   = 1'b0;
            z_out_d = acc_d;
          end else if (!rep_q && is_repeat_idx(idx_q)) begin
            rep_d = 1'b1;
          end else begin
            rep_d = 1'b0;
            idx_d = idx_q + index_t'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  assign bus.ready      = ready_q;
  assign bus.iter_valid = valid_q;
  assign bus.iter_index = idx_q;
  assign bus.iter_dir   = dir_c;
  assign bus.done       = done_q;
  assign bus.z_out      = z_out_q;

endmodule
